// File: rtl/wb_traffic_gen_pkg.sv
// rtl/wb_traffic_gen_pkg.sv - shared types and constants for the Wishbone traffic generator
// Contents: FSM state encoding, Wishbone CTI/BTE codes, LFSR taps, saturating counter helper.
package wb_traffic_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_GAP,
        ST_RD,
        ST_RD_GAP,
        ST_DONE
    } state_t;

    localparam logic [2:0]  CTI_CLASSIC      = 3'b000;
    localparam logic [2:0]  CTI_INC_BURST    = 3'b010;
    localparam logic [2:0]  CTI_END_OF_BURST = 3'b111;
    localparam logic [1:0]  BTE_LINEAR       = 2'b00;
    localparam logic [31:0] LFSR_TAPS        = 32'h8020_0003;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wb_traffic_gen_if.sv
// rtl/wb_traffic_gen_if.sv - Wishbone B3 bus bundle between traffic generator and slave
// Master drives adr/dat_o/sel/we/bte/cti/cyc/stb; slave drives dat_i/ack/err/rty.
interface wb_traffic_gen_if #(
    parameter int dw = 32,
    parameter int aw = 32
);
    logic [aw-1:0]   wb_adr_o;
    logic [dw-1:0]   wb_dat_o;
    logic [dw/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic [1:0]      wb_bte_o;
    logic [2:0]      wb_cti_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [dw-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_tg_lfsr.sv
// rtl/wb_tg_lfsr.sv - 32-bit Galois LFSR pattern source with synchronous load and step
// Ports: wb_clk_i, wb_rst_i (sync, active high, clears to 0), load (q <= SEED), step (advance once), q.
module wb_tg_lfsr
    import wb_traffic_gen_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        load,
    input  logic        step,
    output logic [31:0] q
);

    // Right-shifting Galois form: the bit shifted out folds the taps back in.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            q <= '0;
        end else if (load) begin
            q <= SEED;
        end else if (step) begin
            q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_TAPS : 32'h0);
        end
    end

endmodule

// File: rtl/wb_traffic_gen.sv
// rtl/wb_traffic_gen.sv - Wishbone B3 self-test master: LFSR write pass, read-back compare pass
// Ports: wb_clk_i/wb_rst_i (sync active-high reset), start_i, busy_o, done_o, pass_o,
//        err_cnt_o (saturating), timeout_o, wb (wb_traffic_gen_if.master bus).
// Optional feature macro: WB_TRAFFIC_GEN_TIMEOUT_EN (stall watchdog, drives timeout_o).
module wb_traffic_gen
    import wb_traffic_gen_pkg::*;
#(
    parameter int          dw        = 32,
    parameter int          aw        = 32,
    parameter logic [aw-1:0] BASE_ADR = '0,
    parameter int          NUM_WORDS = 256,
    parameter int          BURST_LEN = 4,
    parameter logic [31:0] SEED      = 32'hACE1_0001,
    parameter int          TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic        timeout_o,
    wb_traffic_gen_if.master wb
);

    localparam int         BYTES     = dw / 8;
    localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);

    if (!(dw == 32 || dw == 64) || BURST_LEN < 1 || BURST_LEN > 16 ||
        (BURST_LEN & (BURST_LEN - 1)) != 0 || NUM_WORDS < 1 ||
        (NUM_WORDS % BURST_LEN) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("wb_traffic_gen: illegal parameter combination");
    end

    state_t        state_q, state_n;
    logic [31:0]   idx_q, idx_n;
    logic [4:0]    beat_q, beat_n;
    logic [15:0]   err_q, err_n;
    logic          cyc_q, cyc_n;
    logic          we_q, we_n;
    logic [2:0]    cti_q, cti_n;
    logic [aw-1:0] adr_q, adr_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          pass_q, pass_n;
    logic          lfsr_load, lfsr_step;
    logic [31:0]   lfsr_q;
    logic [dw-1:0] exp_word;
    logic          beat_done;
`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
    logic [31:0]   stall_q, stall_n;
    logic          tmo_q, tmo_n;
`endif

    // One generator serves both passes; it is reloaded before the read pass
    // so the read side regenerates exactly the written sequence.
    wb_tg_lfsr #(.SEED(SEED)) u_lfsr (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (lfsr_load),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    assign exp_word  = {(dw/32){lfsr_q}};
    // err has priority over ack, but either one retires the beat.
    assign beat_done = wb.wb_err_i | wb.wb_ack_i;

    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        beat_n    = beat_q;
        err_n     = err_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
        stall_n   = stall_q;
        tmo_n     = tmo_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_n   = ST_WR;
                    idx_n     = '0;
                    beat_n    = '0;
                    err_n     = '0;
                    lfsr_load = 1'b1;
`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
                    stall_n   = '0;
                    tmo_n     = 1'b0;
`endif
                end
            end
            ST_WR, ST_RD: begin
                if (wb.wb_err_i) begin
                    err_n = sat_inc16(err_q);
                end else if (wb.wb_ack_i && state_q == ST_RD && wb.wb_dat_i != exp_word) begin
                    err_n = sat_inc16(err_q);
                end
                // rty (or silence) leaves everything in place so the beat is re-presented.
                if (beat_done) begin
                    lfsr_step = 1'b1;
                    idx_n     = idx_q + 32'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_n  = '0;
                        state_n = (state_q == ST_WR) ? ST_WR_GAP : ST_RD_GAP;
                    end else begin
                        beat_n  = beat_q + 5'd1;
                    end
                end
`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
                if (beat_done || wb.wb_rty_i) begin
                    stall_n = '0;
                end else if (stall_q == 32'(TIMEOUT - 1)) begin
                    stall_n = '0;
                    err_n   = sat_inc16(err_q);
                    tmo_n   = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    stall_n = stall_q + 32'd1;
                end
`endif
            end
            ST_WR_GAP: begin
                if (idx_q < 32'(NUM_WORDS)) begin
                    state_n = ST_WR;
                end else begin
                    state_n   = ST_RD;
                    idx_n     = '0;
                    lfsr_load = 1'b1;
                end
            end
            ST_RD_GAP: begin
                state_n = (idx_q < 32'(NUM_WORDS)) ? ST_RD : ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are computed from the next state so they appear registered.
        cyc_n  = (state_n == ST_WR) || (state_n == ST_RD);
        we_n   = (state_n == ST_WR);
        adr_n  = BASE_ADR + aw'(idx_n * 32'(BYTES));
        if (!cyc_n || BURST_LEN == 1) begin
            cti_n = CTI_CLASSIC;
        end else begin
            cti_n = (beat_n == LAST_BEAT) ? CTI_END_OF_BURST : CTI_INC_BURST;
        end
        busy_n = (state_n == ST_WR) || (state_n == ST_WR_GAP) ||
                 (state_n == ST_RD) || (state_n == ST_RD_GAP);
        done_n = (state_n == ST_DONE);
        pass_n = done_n && (err_n == 16'd0);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            beat_q  <= '0;
            err_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            cti_q   <= '0;
            adr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
            stall_q <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            beat_q  <= beat_n;
            err_q   <= err_n;
            cyc_q   <= cyc_n;
            we_q    <= we_n;
            cti_q   <= cti_n;
            adr_q   <= adr_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
            stall_q <= stall_n;
            tmo_q   <= tmo_n;
`endif
        end
    end

    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = exp_word;
    assign wb.wb_sel_o = {BYTES{cyc_q}};
    assign wb.wb_we_o  = we_q;
    assign wb.wb_bte_o = BTE_LINEAR;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_cnt_o   = err_q;
`ifdef WB_TRAFFIC_GEN_TIMEOUT_EN
    assign timeout_o   = tmo_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule
